// File: rtl/text_command_decoder_pkg.sv
// Shared constants for the text video path: command opcodes, attribute
// bit-field layout and the text grid coordinate widths.
package text_command_decoder_pkg;

  // Command opcodes carried in the first byte of every command
  localparam logic [7:0] OP_SET_CURSOR = 8'h01;
  localparam logic [7:0] OP_PUT        = 8'h02;
  localparam logic [7:0] OP_FILL       = 8'h03;

  // Text grid coordinate widths (up to 128 columns, 64 rows)
  localparam int X_W = 7;
  localparam int Y_W = 6;

  // Packed character attribute layout
  localparam int ATTR_W          = 24;
  localparam int ATTR_CHAR_MSB   = 23;
  localparam int ATTR_CHAR_LSB   = 16;
  localparam int ATTR_FG_MSB     = 15;
  localparam int ATTR_FG_LSB     = 12;
  localparam int ATTR_BG_MSB     = 11;
  localparam int ATTR_BG_LSB     = 8;
  localparam int ATTR_SIZE_MSB   = 7;
  localparam int ATTR_SIZE_LSB   = 6;
  localparam int ATTR_PART_MSB   = 5;
  localparam int ATTR_PART_LSB   = 2;
  localparam int ATTR_BLINK_BIT  = 1;
  localparam int ATTR_ULINE_BIT  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARGS,
    ST_PUT,
    ST_FILL
  } state_t;

  typedef enum logic [1:0] {
    CMD_SET,
    CMD_PUT,
    CMD_FILL
  } cmd_t;

endpackage

// File: rtl/text_command_decoder_cursor.sv
// Text cursor: x/y counters with clamped load, row-major advance with
// wrap, and clear. Also exposes the wrapped successor and an end flag so
// the fill sequencer can present the next address one cycle ahead.
module text_cursor
  import text_command_decoder_pkg::*;
#(
  parameter int COLS = 100,
  parameter int ROWS = 60
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           load,
  input  logic [7:0]     load_x,
  input  logic [7:0]     load_y,
  input  logic           advance,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [X_W-1:0] next_x,
  output logic [Y_W-1:0] next_y,
  output logic           at_end
);

  localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

  // Row-major successor of the current cell, wrapping at the grid end
  always_comb begin
    next_x = x + X_W'(1);
    next_y = y;
    if (x == X_LAST) begin
      next_x = '0;
      next_y = (y == Y_LAST) ? '0 : y + Y_W'(1);
    end
  end

  assign at_end = (x == X_LAST) && (y == Y_LAST);

  // Cursor register: clear beats load beats advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (load) begin
      x <= (load_x >= 8'(COLS)) ? X_LAST : load_x[X_W-1:0];
      y <= (load_y >= 8'(ROWS)) ? Y_LAST : load_y[Y_W-1:0];
    end else if (advance) begin
      x <= next_x;
      y <= next_y;
    end
  end

endmodule

// File: rtl/text_command_decoder.sv
// Byte-stream command decoder for the text display. Turns I2C data bytes
// into cursor moves, single-cell writes and whole-screen fills, driving a
// registered write port into the character video memory.
module text_command_decoder
  import text_command_decoder_pkg::*;
#(
  parameter int COLS = 100,
  parameter int ROWS = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              write,
  output logic [X_W-1:0]    xtextwrite,
  output logic [Y_W-1:0]    ytextwrite,
  output logic [ATTR_W-1:0] value
);

  state_t          state;
  cmd_t            cmd;
  logic [1:0]      arg_cnt;
  logic [15:0]     arg_sr;

  logic            accept;
  logic            last_arg;
  logic [ATTR_W-1:0] attr_in;

  logic            cur_clear;
  logic            cur_load;
  logic            cur_advance;
  logic [X_W-1:0]  cur_x;
  logic [Y_W-1:0]  cur_y;
  logic [X_W-1:0]  nxt_x;
  logic [Y_W-1:0]  nxt_y;
  logic            cur_at_end;

  assign byte_ready = (state == ST_IDLE) || (state == ST_ARGS);

  // A byte coinciding with frame_start is dropped
  assign accept   = byte_valid && byte_ready && !frame_start;
  assign last_arg = (cmd == CMD_SET) ? (arg_cnt == 2'd1) : (arg_cnt == 2'd2);
  assign attr_in  = {arg_sr, byte_data};

  // Cursor control: the last operand of SET_CURSOR loads, the last operand
  // of FILL rewinds to (0,0), and every PUT/FILL write cycle steps forward
  always_comb begin
    cur_load    = 1'b0;
    cur_clear   = 1'b0;
    cur_advance = (state == ST_PUT) || (state == ST_FILL);
    if (state == ST_ARGS && accept && last_arg) begin
      cur_load  = (cmd == CMD_SET);
      cur_clear = (cmd == CMD_FILL);
    end
  end

  text_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk     (clk),
    .reset   (reset),
    .clear   (cur_clear),
    .load    (cur_load),
    .load_x  (arg_sr[7:0]),
    .load_y  (byte_data),
    .advance (cur_advance),
    .x       (cur_x),
    .y       (cur_y),
    .next_x  (nxt_x),
    .next_y  (nxt_y),
    .at_end  (cur_at_end)
  );

  // Command FSM with registered write port; the address and value only
  // change together with a write pulse so they stay stable otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cmd        <= CMD_SET;
      arg_cnt    <= 2'd0;
      arg_sr     <= '0;
      write      <= 1'b0;
      xtextwrite <= '0;
      ytextwrite <= '0;
      value      <= '0;
    end else begin
      write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            arg_cnt <= 2'd0;
          end else if (accept) begin
            arg_cnt <= 2'd0;
            case (byte_data)
              OP_SET_CURSOR: begin cmd <= CMD_SET;  state <= ST_ARGS; end
              OP_PUT:        begin cmd <= CMD_PUT;  state <= ST_ARGS; end
              OP_FILL:       begin cmd <= CMD_FILL; state <= ST_ARGS; end
              default:       state <= ST_IDLE;
            endcase
          end
        end

        ST_ARGS: begin
          if (frame_start) begin
            state   <= ST_IDLE;
            arg_cnt <= 2'd0;
          end else if (accept) begin
            arg_sr <= {arg_sr[7:0], byte_data};
            if (last_arg) begin
              arg_cnt <= 2'd0;
              case (cmd)
                CMD_PUT: begin
                  write      <= 1'b1;
                  xtextwrite <= cur_x;
                  ytextwrite <= cur_y;
                  value      <= attr_in;
                  state      <= ST_PUT;
                end
                CMD_FILL: begin
                  write      <= 1'b1;
                  xtextwrite <= '0;
                  ytextwrite <= '0;
                  value      <= attr_in;
                  state      <= ST_FILL;
                end
                default: state <= ST_IDLE;
              endcase
            end else begin
              arg_cnt <= arg_cnt + 2'd1;
            end
          end
        end

        ST_PUT: begin
          state <= ST_IDLE;
        end

        ST_FILL: begin
          if (cur_at_end) begin
            state <= ST_IDLE;
          end else begin
            write      <= 1'b1;
            xtextwrite <= nxt_x;
            ytextwrite <= nxt_y;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_command_decoder.sv
// Directed bench for text_command_decoder: cursor set/clamp, PUT with
// advance and wrap, frame_start abort rules, full-screen FILL and reset
// in the middle of a fill.
module tb_text_command_decoder;

  localparam int COLS = 100;
  localparam int ROWS = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        write;
  logic [6:0]  xtextwrite;
  logic [5:0]  ytextwrite;
  logic [23:0] value;

  int checks = 0;
  int errors = 0;

  // write monitor state (written only by the monitor process)
  int          wr_cnt = 0;
  logic [6:0]  last_x = '0;
  logic [5:0]  last_y = '0;
  logic [23:0] last_val = '0;
  int          fill_bad = 0;
  int          rdy_bad = 0;

  // fill tracking controls (written only by the stimulus process)
  logic        fill_on = 1'b0;
  int          fill_base = 0;
  logic [23:0] fill_val = '0;

  always #5 clk = ~clk;

  text_command_decoder #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .write       (write),
    .xtextwrite  (xtextwrite),
    .ytextwrite  (ytextwrite),
    .value       (value)
  );

  // Count write pulses and verify fill order, value and byte_ready
  always @(negedge clk) begin
    if (write && !reset) begin
      if (fill_on) begin
        int idx;
        idx = wr_cnt - fill_base;
        if (xtextwrite != 7'(idx % COLS) || ytextwrite != 6'(idx / COLS) ||
            value != fill_val)
          fill_bad = fill_bad + 1;
        if (byte_ready)
          rdy_bad = rdy_bad + 1;
      end
      wr_cnt   = wr_cnt + 1;
      last_x   = xtextwrite;
      last_y   = ytextwrite;
      last_val = value;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready)
      check("send_timeout", 32'(n), 32'(0));
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a);
    send_byte(b);
    send_byte(c);
  endtask

  // PUT and check the single write pulse that follows the last operand
  task automatic put_check(input string tag, input logic [23:0] attr,
                           input int ex, input int ey);
    int base;
    base = wr_cnt;
    send_byte(8'h02);
    send3(attr[23:16], attr[15:8], attr[7:0]);
    @(negedge clk);
    check({tag, "_wr"},  32'(write), 32'd1);
    check({tag, "_x"},   32'(xtextwrite), 32'(ex));
    check({tag, "_y"},   32'(ytextwrite), 32'(ey));
    check({tag, "_val"}, 32'(value), 32'(attr));
    check({tag, "_rdy"}, 32'(byte_ready), 32'd0);
    @(negedge clk);
    check({tag, "_wr_off"}, 32'(write), 32'd0);
    #1;
    check({tag, "_cnt"}, 32'(wr_cnt - base), 32'd1);
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    reset       = 1'b1;
    frame_start = 1'b0;
    byte_valid  = 1'b0;
    byte_data   = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_write", 32'(write), 32'd0);
    check("rst_x",     32'(xtextwrite), 32'd0);
    check("rst_y",     32'(ytextwrite), 32'd0);
    check("rst_value", 32'(value), 32'd0);
    check("rst_ready", 32'(byte_ready), 32'd1);

    // Set cursor (5,3), PUT, then cursor advanced to (6,3)
    send3(8'h01, 8'h05, 8'h03);
    put_check("put53", 24'h417200, 5, 3);
    put_check("put63", 24'h000001, 6, 3);

    // Last cell, then wrap to (0,0)
    send3(8'h01, 8'h63, 8'h3B);
    put_check("put_last", 24'h112233, 99, 59);
    put_check("put_wrap", 24'h445566, 0, 0);

    // Clamp out-of-range cursor
    send3(8'h01, 8'hC8, 8'hFF);
    put_check("put_clamp", 24'hABCDEF, 99, 59);

    // Partial PUT aborted by frame_start, then cursor set to (2,2)
    base = wr_cnt;
    send_byte(8'h02);
    send_byte(8'h41);
    pulse_frame();
    send3(8'h01, 8'h02, 8'h02);
    repeat (4) @(negedge clk);
    #1;
    check("abort_nowrite", 32'(wr_cnt - base), 32'd0);
    put_check("put22", 24'h102030, 2, 2);

    // frame_start together with an opcode byte: the byte is dropped;
    // 0x07 is then an unknown opcode and ignored
    @(negedge clk);
    frame_start = 1'b1;
    byte_valid  = 1'b1;
    byte_data   = 8'h02;
    @(negedge clk);
    frame_start = 1'b0;
    byte_valid  = 1'b0;
    send_byte(8'h07);
    put_check("put_drop", 24'hAABBCC, 3, 2);

    // Full-screen FILL with a frame_start in the middle
    fill_base = wr_cnt;
    fill_val  = 24'h200700;
    fill_on   = 1'b1;
    send_byte(8'h03);
    send3(8'h20, 8'h07, 8'h00);
    repeat (50) @(negedge clk);
    pulse_frame();
    n = 0;
    while (n < 8000) begin
      @(negedge clk);
      #1;
      if ((wr_cnt - fill_base) >= COLS * ROWS && !write) break;
      n++;
    end
    fill_on = 1'b0;
    check("fill_count", 32'(wr_cnt - fill_base), 32'(COLS * ROWS));
    check("fill_order", 32'(fill_bad), 32'd0);
    check("fill_ready_low", 32'(rdy_bad), 32'd0);
    check("fill_last_x", 32'(last_x), 32'd99);
    check("fill_last_y", 32'(last_y), 32'd59);
    check("fill_last_val", 32'(last_val), 32'h200700);
    check("fill_ready_after", 32'(byte_ready), 32'd1);
    put_check("put_after_fill", 24'h555555, 0, 0);

    // Reset in the middle of a fill
    fill_base = wr_cnt;
    fill_val  = 24'h313233;
    fill_on   = 1'b1;
    send_byte(8'h03);
    send3(8'h31, 8'h32, 8'h33);
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      #1;
      if ((wr_cnt - fill_base) >= 100) break;
      n++;
    end
    check("prefill_count", 32'(wr_cnt - fill_base), 32'd100);
    fill_on = 1'b0;
    reset = 1'b1;
    #1;
    check("arst_write", 32'(write), 32'd0);
    check("arst_x",     32'(xtextwrite), 32'd0);
    check("arst_y",     32'(ytextwrite), 32'd0);
    check("arst_value", 32'(value), 32'd0);
    base = wr_cnt;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("arst_nowrite", 32'(wr_cnt - base), 32'd0);
    check("arst_ready", 32'(byte_ready), 32'd1);
    send_byte(8'hFF);
    repeat (5) @(negedge clk);
    #1;
    check("ff_ignored", 32'(wr_cnt - base), 32'd0);
    put_check("put_after_rst", 24'h0A0B0C, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/text_command_decoder.md
TEXT_COMMAND_DECODER -- requirements
Module: text_command_decoder

Interface
REQ-001 SHALL have parameter COLS, default 100, meaning text columns (800 px / 8 px cells).
REQ-002 SHALL have parameter ROWS, default 60, meaning text rows.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all logic is in this one clock domain.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port frame_start, input, 1, meaning a one-cycle pulse from the I2C slave on START plus address match.
REQ-006 SHALL have port byte_valid, input, 1, meaning byte_data holds a received I2C data byte.
REQ-007 SHALL have port byte_data, input, 8, meaning the received byte.
REQ-008 SHALL have port byte_ready, output, 1, meaning a byte is accepted when byte_valid and byte_ready are both high.
REQ-009 SHALL have port write, output, 1, meaning a one-cycle video memory write strobe.
REQ-010 SHALL have port xtextwrite, output, 7, meaning the column written (0..COLS-1).
REQ-011 SHALL have port ytextwrite, output, 6, meaning the row written (0..ROWS-1).
REQ-012 SHALL have port value, output, 24, meaning the packed character attribute (charindex, fg, bg, size, part, blink, underline).

Function
REQ-013 SHALL implement FSM states IDLE, ARGS, PUT, FILL.
REQ-014 IDLE, opcode byte: 0x01 SET_CURSOR (2 args x,y); 0x02 PUT (3 args attr[23:16],[15:8],[7:0]); 0x03 FILL (3 args, same order); any other opcode consumed and ignored, stay IDLE.
REQ-015 ARGS SHALL collect the operands MSB-first via a 2-bit argument counter, then exit as follows: SET_CURSOR -> IDLE; PUT -> PUT; FILL -> FILL.
REQ-016 SET_CURSOR SHALL clamp: x>=COLS -> COLS-1, y>=ROWS -> ROWS-1; cursor updated the cycle after the y byte is accepted; no write.
REQ-017 PUT SHALL assert write for exactly one cycle, the cycle after the last operand is accepted, with cursor on x/ytextwrite and the attribute on value; return to IDLE.
REQ-018 After a PUT, cursor SHALL advance: x+1; at x=COLS-1 wrap to x=0, y+1; at (COLS-1,ROWS-1) wrap to (0,0).
REQ-019 FILL SHALL write every cell, one per cycle, row-major from (0,0) to (COLS-1,ROWS-1): exactly COLS*ROWS consecutive write pulses (6000 by default); then cursor=(0,0) and return to IDLE.
REQ-020 byte_ready SHALL be high in IDLE/ARGS and low in PUT/FILL; byte_valid while not ready is not consumed.
REQ-021 frame_start in IDLE/ARGS SHALL discard partial operands and enter IDLE in the next cycle; the cursor is kept.
REQ-022 frame_start in PUT/FILL SHALL be ignored; the operation completes.
REQ-023 If frame_start and an accepted byte occur in the same cycle, frame_start SHALL win and the byte SHALL be dropped.
REQ-024 write, xtextwrite, ytextwrite, value SHALL be registered outputs; value and address are held stable whenever write is low.

Reset
REQ-025 Reset SHALL asynchronously force: state=IDLE, cursor=(0,0), arg counter=0, write=0, xtextwrite=0, ytextwrite=0, value=0, byte_ready=1 after release.
REQ-026 Reset during FILL SHALL abort the fill immediately with no further write pulses.

Structure
REQ-027 Opcode constants, the attribute bit-field ranges, and the COLS/ROWS widths SHALL live in the shared constant include used by video_memory and the I2C slave.
REQ-028 A sub-module text_cursor SHALL hold the x/y counters with load (clamped), advance (wrap) and clear operations, shared by PUT and FILL.

Verification
REQ-029 Send 01 05 03, then 02 41 72 00 -> one write at (5,3), value=0x417200; cursor becomes (6,3).
REQ-030 Send 01 63 3B (99,59), then PUT -> write at (99,59), cursor wraps to (0,0); a second PUT -> write at (0,0).
REQ-031 Send 01 C8 FF -> cursor clamped to (99,59); the next PUT writes at (99,59).
REQ-032 Send 03 20 07 00 -> 6000 consecutive writes, first (0,0), last (99,59), value=0x200700 on all; byte_ready=0 throughout; frame_start pulse mid-fill has no effect.
REQ-033 Send 02 41, then frame_start, then 01 02 02 -> no write; cursor=(2,2).
REQ-034 Assert reset after 100 FILL writes -> write=0 at once, all outputs 0, state IDLE; opcode 0xFF afterwards -> ignored, no write.
